// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state encodings, opcodes and field helpers for the run-control block
package pipeline_pkg;
  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_RUN    = 3'b001;
  localparam logic [2:0] S_STALL  = 3'b010;
  localparam logic [2:0] S_STEP   = 3'b011;
  localparam logic [2:0] S_DRAIN  = 3'b100;
  localparam logic [2:0] S_HALTED = 3'b101;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  function automatic logic [3:0] op_of(input logic [15:0] ir);
    return ir[15:12];
  endfunction
  function automatic logic [1:0] rs_of(input logic [15:0] ir);
    return ir[11:10];
  endfunction
  function automatic logic [1:0] rt_of(input logic [15:0] ir);
    return ir[9:8];
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a RAW dependency between ID/EX and IF/ID when forwarding is off
module hazard_detect import pipeline_pkg::*; #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [15:0] ifid_ir,
  input  logic        idex_regwrite,
  input  logic [1:0]  idex_wr,
  output logic        hazard
);
  logic [3:0] op;
  assign op = op_of(ifid_ir);
  // addi's second field is its destination, so only the ops below addi read it as a source
  assign hazard = !FORWARD_EN && idex_regwrite && idex_wr != 2'b00 && op <= OP_ADDI &&
                  (idex_wr == rs_of(ifid_ir) || (op < OP_ADDI && idex_wr == rt_of(ifid_ir)));
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/stall/step/drain control and issue statistics for the two-stage pipeline
module pipeline_sequencer import pipeline_pkg::*; #(
  parameter bit          FORWARD_EN   = 1'b1,
  parameter int          STALL_CYCLES = 1,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [15:0] HALT_WORD    = HALT_WORD_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        pause,
  input  logic        step,
  input  logic [15:0] ifid_ir,
  input  logic        idex_regwrite,
  input  logic [1:0]  idex_wr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);
  logic [2:0] state_q, state_d, scnt_q, scnt_d, dcnt_q, dcnt_d;
  logic ret_step_q, ret_step_d, halted_q, halted_d;
  logic [15:0] issue_q, issue_d, stall_q, stall_d;
  logic hazard, run_like, is_halt, issue, bubble_edge;
  hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_hazard (
    .ifid_ir(ifid_ir),
    .idex_regwrite(idex_regwrite),
    .idex_wr(idex_wr),
    .hazard(hazard)
  );
  assign run_like    = state_q == S_RUN || state_q == S_STEP;
  assign is_halt     = ifid_ir == HALT_WORD;
  assign issue       = resetn && run_like && !hazard && !is_halt;
  assign bubble_edge = (run_like && hazard) || state_q == S_STALL;
  assign pc_en       = issue;
  assign ifid_en     = issue;
  assign idex_bubble = !issue;
  assign state       = state_q;
  assign halted      = halted_q;
  assign issue_cnt   = issue_q;
  assign stall_cnt   = stall_q;
  // next state, stall/drain countdowns and saturating statistics for the coming falling edge
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    dcnt_d     = dcnt_q;
    ret_step_d = ret_step_q;
    halted_d   = halted_q;
    issue_d    = issue && issue_q != 16'hFFFF ? issue_q + 16'd1 : issue_q;
    stall_d    = bubble_edge && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
    case (state_q)
      S_RUN, S_STEP:
        if (hazard) begin
          if (STALL_CYCLES > 1) begin
            state_d    = S_STALL;
            scnt_d     = 3'(STALL_CYCLES - 1);
            ret_step_d = state_q == S_STEP;
          end
        end else if (is_halt) begin
          state_d = S_DRAIN;
          dcnt_d  = 3'(DRAIN_CYCLES - 1);
        end else if (state_q == S_STEP || pause) begin
          state_d = S_IDLE;
        end
      S_STALL: begin
        scnt_d = scnt_q - 3'd1;
        if (scnt_q <= 3'd1) state_d = ret_step_q ? S_STEP : S_RUN;
      end
      S_DRAIN:
        if (dcnt_q == 3'd0) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      S_HALTED: state_d = S_HALTED;
      default: state_d = start ? S_RUN : step ? S_STEP : S_IDLE;
    endcase
  end
  // all state moves on the falling edge to line up with the datapath registers
  always_ff @(negedge clock or negedge resetn)
    if (!resetn) begin
      state_q    <= S_IDLE;
      scnt_q     <= 3'd0;
      dcnt_q     <= 3'd0;
      ret_step_q <= 1'b0;
      halted_q   <= 1'b0;
      issue_q    <= 16'd0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      dcnt_q     <= dcnt_d;
      ret_step_q <= ret_step_d;
      halted_q   <= halted_d;
      issue_q    <= issue_d;
      stall_q    <= stall_d;
    end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: scoreboard bench over three parameterisations of the sequencer
module tb_pipeline_sequencer;
  localparam int IDLE = 0, RUN = 1, STALL = 2, STEP = 3, DRAIN = 4, HALTED = 5;
  typedef struct {
    int          d;
    logic [38:0] v;
    string       nm;
  } exp_t;
  logic clock = 1'b1, resetn = 1'b0, start = 1'b0, pause = 1'b0, step = 1'b0, idex_regwrite = 1'b0;
  logic [15:0] ifid_ir = 16'd0;
  logic [1:0] idex_wr = 2'd0;
  logic pc_en [3], ifid_en [3], idex_bubble [3], halted [3];
  logic [2:0] state [3];
  logic [15:0] issue_cnt [3], stall_cnt [3];
  exp_t q [$];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  // dut0: forwarding on; dut1: no forwarding, 3 bubbles; dut2: no forwarding, 1 bubble
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_sequencer #(
      .FORWARD_EN(g == 0), .STALL_CYCLES(g == 1 ? 3 : 1), .DRAIN_CYCLES(2), .HALT_WORD(16'hFFFF)
    ) u_dut (
      .clock(clock), .resetn(resetn), .start(start), .pause(pause), .step(step),
      .ifid_ir(ifid_ir), .idex_regwrite(idex_regwrite), .idex_wr(idex_wr),
      .pc_en(pc_en[g]), .ifid_en(ifid_en[g]), .idex_bubble(idex_bubble[g]), .halted(halted[g]),
      .state(state[g]), .issue_cnt(issue_cnt[g]), .stall_cnt(stall_cnt[g])
    );
  end
  // monitor: compares the selected DUT mid-cycle, away from the falling active edge
  always @(posedge clock) begin
    exp_t e;
    logic [38:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_en[e.d], ifid_en[e.d], idex_bubble[e.d], halted[e.d], state[e.d], issue_cnt[e.d], stall_cnt[e.d]};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s dut%0d: got pc=%b if=%b bub=%b h=%b st=%0d ic=%0d sc=%0d, expected pc=%b if=%b bub=%b h=%b st=%0d ic=%0d sc=%0d",
                 e.nm, e.d, a[38], a[37], a[36], a[35], a[34:32], a[31:16], a[15:0],
                 e.v[38], e.v[37], e.v[36], e.v[35], e.v[34:32], e.v[31:16], e.v[15:0]);
      end
    end
  end
  task automatic push(input int d, input int e, input int es, input int eh, input int eic, input int esc, input string nm);
    exp_t x;
    x.d  = d;
    x.v  = {1'(e), 1'(e), !1'(e), 1'(eh), 3'(es), 16'(eic), 16'(esc)};
    x.nm = nm;
    q.push_back(x);
  endtask
  task automatic cyc(input int d, input int st, input int pa, input int sp, input int ir, input int rw, input int wr,
                     input int e, input int es, input int eh, input int eic, input int esc, input string nm);
    @(negedge clock);
    #1;
    start = 1'(st); pause = 1'(pa); step = 1'(sp);
    ifid_ir = 16'(ir); idex_regwrite = 1'(rw); idex_wr = 2'(wr);
    push(d, e, es, eh, eic, esc, nm);
  endtask
  task automatic areset(input int d, input string nm);
    @(negedge clock);
    #1;
    resetn = 1'b0;
    start = 1'b0; pause = 1'b0; step = 1'b0; ifid_ir = 16'd0; idex_regwrite = 1'b0; idex_wr = 2'd0;
    #1;
    push(d, 0, IDLE, 0, 0, 0, nm);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask
  initial begin
    areset(0, "reset_state");
    cyc(0, 0, 0, 0, 'h710F, 0, 0, 0, IDLE,   0, 0, 0, "idle_hold");
    cyc(0, 1, 0, 0, 'h710F, 0, 0, 0, IDLE,   0, 0, 0, "start");
    cyc(0, 0, 0, 0, 'h710F, 0, 0, 1, RUN,    0, 0, 0, "fwd_addi1");
    cyc(0, 0, 0, 0, 'h7207, 1, 1, 1, RUN,    0, 1, 0, "fwd_addi2");
    cyc(0, 0, 0, 0, 'hFFFF, 1, 2, 0, RUN,    0, 2, 0, "halt_word");
    cyc(0, 0, 0, 0, 'hFFFF, 0, 0, 0, DRAIN,  0, 2, 0, "drain1");
    cyc(0, 1, 0, 1, 'hFFFF, 0, 0, 0, DRAIN,  0, 2, 0, "drain2");
    cyc(0, 1, 0, 1, 'h710F, 0, 0, 0, HALTED, 1, 2, 0, "halted_start");
    cyc(0, 0, 1, 1, 'h710F, 0, 0, 0, HALTED, 1, 2, 0, "halted_sticky");
    areset(0, "reset_from_halt");
    cyc(0, 1, 0, 0, 'h26C0, 1, 1, 0, IDLE,   0, 0, 0, "restart");
    cyc(0, 0, 0, 0, 'h26C0, 1, 1, 1, RUN,    0, 0, 0, "fwd_raw_no_stall");
    cyc(0, 0, 0, 0, 'h7207, 0, 0, 1, RUN,    0, 1, 0, "fwd_after");
    areset(1, "reset1");
    cyc(1, 1, 0, 0, 'h0000, 0, 0, 0, IDLE,   0, 0, 0, "start1");
    cyc(1, 0, 0, 0, 'h710F, 0, 0, 1, RUN,    0, 0, 0, "issue_addi");
    cyc(1, 0, 0, 0, 'h26C0, 1, 1, 0, RUN,    0, 1, 0, "raw_rs_hazard");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 0, STALL,  0, 1, 1, "stall_a");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 0, STALL,  0, 1, 2, "stall_b");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 1, RUN,    0, 1, 3, "resume");
    cyc(1, 0, 0, 0, 'h710F, 1, 1, 1, RUN,    0, 2, 3, "addi_rt_dest");
    cyc(1, 0, 0, 0, 'h26C0, 1, 0, 1, RUN,    0, 3, 3, "wr_zero");
    cyc(1, 0, 0, 0, 'h710F, 1, 2, 1, RUN,    0, 4, 3, "addi_no_match");
    cyc(1, 0, 1, 0, 'h26C0, 1, 2, 0, RUN,    0, 5, 3, "raw_rt_over_pause");
    cyc(1, 0, 1, 0, 'h26C0, 0, 0, 0, STALL,  0, 5, 4, "stall_c");
    cyc(1, 0, 1, 0, 'h26C0, 0, 0, 0, STALL,  0, 5, 5, "stall_d");
    cyc(1, 0, 1, 0, 'h7207, 0, 0, 1, RUN,    0, 5, 6, "pause_issue");
    cyc(1, 0, 0, 1, 'h26C0, 1, 1, 0, IDLE,   0, 6, 6, "step_req");
    cyc(1, 0, 0, 0, 'h26C0, 1, 1, 0, STEP,   0, 6, 6, "step_hazard");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 0, STALL,  0, 6, 7, "step_stall_a");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 0, STALL,  0, 6, 8, "step_stall_b");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 1, STEP,   0, 6, 9, "step_issue");
    cyc(1, 0, 0, 0, 'h26C0, 0, 0, 0, IDLE,   0, 7, 9, "step_done");
    cyc(1, 1, 0, 0, 'h26C0, 1, 1, 0, IDLE,   0, 7, 9, "start2");
    cyc(1, 0, 0, 0, 'h26C0, 1, 1, 0, RUN,    0, 7, 9, "hazard2");
    cyc(1, 0, 0, 0, 'h26C0, 1, 1, 0, STALL,  0, 7, 10, "mid_stall");
    areset(1, "reset_mid_stall");
    cyc(1, 1, 0, 0, 'h0000, 0, 0, 0, IDLE,   0, 0, 0, "start3");
    cyc(1, 0, 0, 0, 'h710F, 0, 0, 1, RUN,    0, 0, 0, "no_residue");
    cyc(1, 0, 0, 0, 'hFFFF, 0, 0, 0, RUN,    0, 1, 0, "halt1");
    cyc(1, 0, 0, 0, 'hFFFF, 0, 0, 0, DRAIN,  0, 1, 0, "mid_drain");
    areset(1, "reset_mid_drain");
    cyc(1, 0, 0, 1, 'hFFFF, 0, 0, 0, IDLE,   0, 0, 0, "step_halt_req");
    cyc(1, 0, 0, 0, 'hFFFF, 0, 0, 0, STEP,   0, 0, 0, "step_halt");
    cyc(1, 0, 0, 0, 'hFFFF, 0, 0, 0, DRAIN,  0, 0, 0, "drain_s1");
    cyc(1, 0, 0, 0, 'hFFFF, 0, 0, 0, DRAIN,  0, 0, 0, "drain_s2");
    cyc(1, 1, 0, 1, 'h710F, 0, 0, 0, HALTED, 1, 0, 0, "halted_s");
    areset(2, "reset2");
    cyc(2, 1, 0, 1, 'h0000, 0, 0, 0, IDLE,   0, 0, 0, "start_and_step");
    cyc(2, 0, 0, 0, 'h710F, 0, 0, 1, RUN,    0, 0, 0, "run_not_step");
    cyc(2, 0, 0, 0, 'h26C0, 1, 1, 0, RUN,    0, 1, 0, "hazard_1cyc");
    cyc(2, 0, 0, 0, 'h26C0, 0, 0, 1, RUN,    0, 1, 1, "after_1cyc");
    cyc(2, 0, 1, 0, 'h710F, 0, 0, 1, RUN,    0, 2, 1, "pause");
    cyc(2, 0, 0, 1, 'h710F, 0, 0, 0, IDLE,   0, 3, 1, "step_only");
    cyc(2, 0, 0, 0, 'h710F, 0, 0, 1, STEP,   0, 3, 1, "step_pulse");
    cyc(2, 0, 0, 0, 'h710F, 0, 0, 0, IDLE,   0, 4, 1, "step_back_idle");
    repeat (3) @(posedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
